// File: rtl/eth_mdio_resp_pkg.sv
// rtl/eth_mdio_resp_pkg.sv - shared MDIO Clause 22 constants, state encodings and helpers
package eth_mdio_resp_pkg;

    localparam int MDIO_DATA_W = 16;
    localparam int MDIO_ADDR_W = 5;

    localparam logic [1:0] MDIO_OP_RD = 2'b10;
    localparam logic [1:0] MDIO_OP_WR = 2'b01;
    localparam logic [1:0] MDIO_ST    = 2'b01;

    typedef logic [3:0] mdio_resp_state_t;

    localparam mdio_resp_state_t S_IDLE    = 4'd0;
    localparam mdio_resp_state_t S_ST      = 4'd1;
    localparam mdio_resp_state_t S_OP      = 4'd2;
    localparam mdio_resp_state_t S_PHYAD   = 4'd3;
    localparam mdio_resp_state_t S_REGAD   = 4'd4;
    localparam mdio_resp_state_t S_TA      = 4'd5;
    localparam mdio_resp_state_t S_RD_DATA = 4'd6;
    localparam mdio_resp_state_t S_WR_DATA = 4'd7;
    localparam mdio_resp_state_t S_SKIP    = 4'd8;

    function automatic logic op_valid(input logic [1:0] op);
        return (op == MDIO_OP_RD) || (op == MDIO_OP_WR);
    endfunction

endpackage

// File: rtl/eth_mdio_resp_if.sv
// rtl/eth_mdio_resp_if.sv - register-file access bus between the MDIO responder and its PHY registers
interface eth_mdio_resp_if;
    import eth_mdio_resp_pkg::*;

    logic                   rd_en;
    logic [MDIO_ADDR_W-1:0] rd_addr;
    logic [MDIO_DATA_W-1:0] rd_data;
    logic                   wr_en;
    logic [MDIO_ADDR_W-1:0] wr_addr;
    logic [MDIO_DATA_W-1:0] wr_data;

    modport master (output rd_en, rd_addr, wr_en, wr_addr, wr_data, input rd_data);
    modport slave  (input rd_en, rd_addr, wr_en, wr_addr, wr_data, output rd_data);
endinterface

// File: rtl/eth_mdio_resp_sync_edge.sv
// rtl/eth_mdio_resp_sync_edge.sv - MDC/MDIO synchroniser with MDC rising-edge pulse
module eth_mdio_resp_sync_edge #(
    parameter int SYNC_LEN = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic mdc,
    input  logic mdio_in,
    output logic rise,
    output logic mdio_s
);
    logic [SYNC_LEN-1:0] mdc_sr;
    logic [SYNC_LEN-1:0] mdio_sr;
    logic                mdc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mdc_sr  <= '0;
            mdio_sr <= '0;
            mdc_d   <= 1'b0;
        end else begin
            mdc_sr  <= {mdc_sr[SYNC_LEN-2:0], mdc};
            mdio_sr <= {mdio_sr[SYNC_LEN-2:0], mdio_in};
            mdc_d   <= mdc_sr[SYNC_LEN-1];
        end
    end

    assign rise   = mdc_sr[SYNC_LEN-1] & ~mdc_d;
    assign mdio_s = mdio_sr[SYNC_LEN-1];
endmodule

// File: rtl/eth_mdio_resp.sv
// rtl/eth_mdio_resp.sv - PHY-side MDIO Clause 22 responder serving a 32x16 register interface
module eth_mdio_resp
    import eth_mdio_resp_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR = 5'd1,
    parameter bit         BCAST_EN = 1'b0,
    parameter int         PRE_LEN  = 32,
    parameter int         SYNC_LEN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mdc,
    input  logic              mdio_in,
    output logic              mdio_out,
    output logic              mdio_oe,
    output logic              mdio_busy,
    eth_mdio_resp_if.master   reg_if
);
    localparam logic [5:0] PRE_THR = 6'(PRE_LEN);

    logic             rise;
    logic             mdio_s;
    mdio_resp_state_t state;
    logic [5:0]       pre_cnt;
    logic [4:0]       bit_cnt;
    logic [1:0]       op;
    logic [4:0]       phyad;
    logic [4:0]       regad;
    logic [15:0]      shreg;
    logic [4:0]       regad_nxt;
    logic             addr_hit;

    eth_mdio_resp_sync_edge #(.SYNC_LEN(SYNC_LEN)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .mdc     (mdc),
        .mdio_in (mdio_in),
        .rise    (rise),
        .mdio_s  (mdio_s)
    );

    // Broadcast address only ever accepts writes; reads to 0 fall into SKIP.
    assign regad_nxt = {shreg[3:0], mdio_s};
    assign addr_hit  = (phyad == PHY_ADDR) ||
                       (BCAST_EN && (phyad == 5'd0) && (op == MDIO_OP_WR));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            pre_cnt        <= '0;
            bit_cnt        <= '0;
            op             <= '0;
            phyad          <= '0;
            regad          <= '0;
            shreg          <= '0;
            mdio_out       <= 1'b0;
            mdio_oe        <= 1'b0;
            mdio_busy      <= 1'b0;
            reg_if.rd_en   <= 1'b0;
            reg_if.rd_addr <= '0;
            reg_if.wr_en   <= 1'b0;
            reg_if.wr_addr <= '0;
            reg_if.wr_data <= '0;
        end else begin
            reg_if.rd_en <= 1'b0;
            reg_if.wr_en <= 1'b0;
            if (rise) begin
                case (state)
                    S_IDLE: begin
                        if (mdio_s) begin
                            if (pre_cnt != 6'd63) pre_cnt <= pre_cnt + 6'd1;
                        end else if (pre_cnt >= PRE_THR) begin
                            state     <= S_ST;
                            mdio_busy <= 1'b1;
                            pre_cnt   <= '0;
                        end else begin
                            pre_cnt <= '0;
                        end
                    end
                    S_ST: begin
                        bit_cnt <= '0;
                        if ({1'b0, mdio_s} == MDIO_ST) begin
                            state <= S_OP;
                        end else begin
                            state     <= S_IDLE;
                            mdio_busy <= 1'b0;
                        end
                    end
                    S_OP: begin
                        op      <= {op[0], mdio_s};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd1) begin
                            bit_cnt <= '0;
                            if (op_valid({op[0], mdio_s})) begin
                                state <= S_PHYAD;
                            end else begin
                                state     <= S_IDLE;
                                mdio_busy <= 1'b0;
                            end
                        end
                    end
                    S_PHYAD: begin
                        phyad   <= {phyad[3:0], mdio_s};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd4) begin
                            bit_cnt <= '0;
                            state   <= S_REGAD;
                        end
                    end
                    S_REGAD: begin
                        shreg   <= {shreg[14:0], mdio_s};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd4) begin
                            bit_cnt <= '0;
                            regad   <= regad_nxt;
                            if (!addr_hit) begin
                                state <= S_SKIP;
                            end else begin
                                state <= S_TA;
                                if (op == MDIO_OP_RD) begin
                                    reg_if.rd_en   <= 1'b1;
                                    reg_if.rd_addr <= regad_nxt;
                                end
                            end
                        end
                    end
                    // Read owns the second TA bit; write just lets both TA bits pass.
                    S_TA: begin
                        bit_cnt <= bit_cnt + 5'd1;
                        if (op == MDIO_OP_RD) begin
                            mdio_oe  <= 1'b1;
                            mdio_out <= 1'b0;
                            shreg    <= reg_if.rd_data;
                            state    <= S_RD_DATA;
                        end else if (bit_cnt == 5'd1) begin
                            state <= S_WR_DATA;
                        end
                    end
                    S_RD_DATA: begin
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd17) begin
                            mdio_oe   <= 1'b0;
                            mdio_out  <= 1'b0;
                            mdio_busy <= 1'b0;
                            pre_cnt   <= '0;
                            state     <= S_IDLE;
                        end else begin
                            mdio_out <= shreg[15];
                            shreg    <= {shreg[14:0], 1'b0};
                        end
                    end
                    S_WR_DATA: begin
                        shreg   <= {shreg[14:0], mdio_s};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd17) begin
                            reg_if.wr_en   <= 1'b1;
                            reg_if.wr_addr <= regad;
                            reg_if.wr_data <= {shreg[14:0], mdio_s};
                            mdio_busy      <= 1'b0;
                            pre_cnt        <= '0;
                            state          <= S_IDLE;
                        end
                    end
                    S_SKIP: begin
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd17) begin
                            mdio_busy <= 1'b0;
                            pre_cnt   <= '0;
                            state     <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_eth_mdio_resp.sv
// tb/tb_eth_mdio_resp.sv - directed station-model bench for eth_mdio_resp
module tb_eth_mdio_resp;
    import eth_mdio_resp_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mdc = 1'b0;
    logic mdio_in = 1'b1;
    logic mdio_out;
    logic mdio_oe;
    logic mdio_busy;

    eth_mdio_resp_if rif();

    eth_mdio_resp #(
        .PHY_ADDR (5'd1),
        .BCAST_EN (1'b0),
        .PRE_LEN  (32),
        .SYNC_LEN (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mdc       (mdc),
        .mdio_in   (mdio_in),
        .mdio_out  (mdio_out),
        .mdio_oe   (mdio_oe),
        .mdio_busy (mdio_busy),
        .reg_if    (rif.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int half  = 4;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [15:0] regs [32];
    int          rd_cnt, wr_cnt;
    logic        oe_seen, busy_seen;
    logic [4:0]  last_rd_addr, last_wr_addr;
    logic [15:0] last_wr_data;

    always @(posedge clk) if (rif.rd_en) rif.rd_data <= regs[rif.rd_addr];

    always @(negedge clk) begin
        if (rif.rd_en) begin
            rd_cnt++;
            last_rd_addr = rif.rd_addr;
        end
        if (rif.wr_en) begin
            wr_cnt++;
            last_wr_addr = rif.wr_addr;
            last_wr_data = rif.wr_data;
            regs[rif.wr_addr] = rif.wr_data;
        end
        if (mdio_oe) oe_seen = 1'b1;
        if (mdio_busy) busy_seen = 1'b1;
    end

    task automatic clr_mon;
        rd_cnt = 0; wr_cnt = 0; oe_seen = 1'b0; busy_seen = 1'b0;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Station-side MDC period; samples what the responder drove after the previous rise.
    task automatic mdc_cycle(input logic b, output logic so, output logic soe);
        mdio_in = b;
        wait_clk(half);
        so  = mdio_out;
        soe = mdio_oe;
        mdc = 1'b1;
        wait_clk(half);
        mdc = 1'b0;
    endtask

    task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                         input logic [4:0] rega, input logic [15:0] wd,
                         input int rst_at, input int pause_at,
                         output logic [16:0] rd17, output int oe_n);
        logic [13:0] hdr;
        logic b, so, soe;
        int k;
        hdr  = {2'b01, op, phy, rega};
        rd17 = '0;
        oe_n = 0;
        for (int i = 0; i < pre + 32; i++) begin
            k = i - (pre + 13);
            if (i < pre) b = 1'b1;
            else if (i < pre + 14) b = hdr[13 - (i - pre)];
            else if (op == MDIO_OP_WR) b = (k == 1) ? 1'b1 : (k == 2) ? 1'b0 : wd[18 - k];
            else b = 1'b1;
            mdc_cycle(b, so, soe);
            if (soe) oe_n++;
            if (k >= 2 && k <= 18) rd17 = {rd17[15:0], so};
            if (k == rst_at) begin
                chk("rst_pre_oe", {31'd0, mdio_oe}, 32'd1);
                @(negedge clk);
                rst = 1'b1;
                #1;
                chk("rst_async_oe", {31'd0, mdio_oe}, 32'd0);
                chk("rst_async_busy", {31'd0, mdio_busy}, 32'd0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (k == pause_at) begin
                wait_clk(300);
                chk("pause_busy", {31'd0, mdio_busy}, 32'd1);
            end
        end
        if (mdio_oe) oe_n++;
    endtask

    logic [16:0] rd17;
    int          oe_n;
    logic        so_d, soe_d;

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 16'h0000;
        regs[1] = 16'hA5C3;
        regs[2] = 16'h0022;
        regs[5] = 16'h1234;
        clr_mon();
        wait_clk(3);
        chk("rst_oe",    {31'd0, mdio_oe},   32'd0);
        chk("rst_out",   {31'd0, mdio_out},  32'd0);
        chk("rst_busy",  {31'd0, mdio_busy}, 32'd0);
        chk("rst_rd_en", {31'd0, rif.rd_en}, 32'd0);
        chk("rst_wr_en", {31'd0, rif.wr_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_clk(4);

        clr_mon();
        frame(32, MDIO_OP_RD, 5'd1, 5'd2, 16'h0, 99, 99, rd17, oe_n);
        chk("rd2_serial", {15'd0, rd17}, {15'd0, 1'b0, 16'h0022});
        chk("rd2_rd_cnt", rd_cnt, 1);
        chk("rd2_addr", {27'd0, last_rd_addr}, 32'd2);
        chk("rd2_oe_n", oe_n, 17);
        chk("rd2_tail_oe", {31'd0, mdio_oe}, 32'd0);
        chk("rd2_tail_busy", {31'd0, mdio_busy}, 32'd0);
        chk("rd2_wr_cnt", wr_cnt, 0);

        clr_mon();
        frame(32, MDIO_OP_WR, 5'd1, 5'd0, 16'h3100, 99, 99, rd17, oe_n);
        chk("wr0_wr_cnt", wr_cnt, 1);
        chk("wr0_addr", {27'd0, last_wr_addr}, 32'd0);
        chk("wr0_data", {16'd0, last_wr_data}, 32'h3100);
        chk("wr0_oe_seen", {31'd0, oe_seen}, 32'd0);
        chk("wr0_tail_busy", {31'd0, mdio_busy}, 32'd0);

        clr_mon();
        frame(32, MDIO_OP_RD, 5'd3, 5'd2, 16'h0, 99, 99, rd17, oe_n);
        chk("skip_rd_cnt", rd_cnt, 0);
        chk("skip_oe_seen", {31'd0, oe_seen}, 32'd0);
        chk("skip_busy_seen", {31'd0, busy_seen}, 32'd1);
        chk("skip_tail_busy", {31'd0, mdio_busy}, 32'd0);
        clr_mon();
        frame(32, MDIO_OP_RD, 5'd1, 5'd5, 16'h0, 99, 99, rd17, oe_n);
        chk("rd5_serial", {15'd0, rd17}, {15'd0, 1'b0, 16'h1234});
        chk("rd5_rd_cnt", rd_cnt, 1);

        mdc_cycle(1'b0, so_d, soe_d);
        clr_mon();
        frame(31, MDIO_OP_RD, 5'd1, 5'd2, 16'h0, 99, 99, rd17, oe_n);
        chk("pre31_busy_seen", {31'd0, busy_seen}, 32'd0);
        chk("pre31_rd_cnt", rd_cnt, 0);
        mdc_cycle(1'b0, so_d, soe_d);
        clr_mon();
        frame(32, MDIO_OP_RD, 5'd1, 5'd2, 16'h0, 99, 99, rd17, oe_n);
        chk("pre32_rd_cnt", rd_cnt, 1);
        chk("pre32_serial", {15'd0, rd17}, {15'd0, 1'b0, 16'h0022});

        clr_mon();
        frame(32, 2'b11, 5'd1, 5'd2, 16'h0, 99, 99, rd17, oe_n);
        chk("op11_busy_seen", {31'd0, busy_seen}, 32'd1);
        chk("op11_rd_wr", rd_cnt + wr_cnt, 0);
        chk("op11_oe_seen", {31'd0, oe_seen}, 32'd0);
        chk("op11_tail_busy", {31'd0, mdio_busy}, 32'd0);

        clr_mon();
        frame(32, MDIO_OP_WR, 5'd1, 5'd7, 16'hBEEF, 99, 5, rd17, oe_n);
        chk("pause_wr_cnt", wr_cnt, 1);
        chk("pause_wr_data", {16'd0, last_wr_data}, 32'hBEEF);

        clr_mon();
        frame(32, MDIO_OP_RD, 5'd1, 5'd2, 16'h0, 9, 99, rd17, oe_n);
        wait_clk(10);
        frame(32, MDIO_OP_RD, 5'd1, 5'd1, 16'h0, 99, 99, rd17, oe_n);
        chk("postrst_serial", {15'd0, rd17}, {15'd0, 1'b0, 16'hA5C3});
        chk("postrst_addr", {27'd0, last_rd_addr}, 32'd1);
        chk("postrst_oe_n", oe_n, 17);
        chk("postrst_wr_cnt", wr_cnt, 0);

        for (int pass = 0; pass < 2; pass++) begin
            half = (pass == 0) ? 4 : 20;
            clr_mon();
            frame(32, MDIO_OP_WR, 5'd1, (pass == 0) ? 5'd9 : 5'd10,
                  (pass == 0) ? 16'h5A0F : 16'hC3A5, 99, 99, rd17, oe_n);
            frame(32, MDIO_OP_RD, 5'd1, (pass == 0) ? 5'd9 : 5'd10, 16'h0, 99, 99, rd17, oe_n);
            chk("b2b_wr_cnt", wr_cnt, 1);
            chk("b2b_rd_cnt", rd_cnt, 1);
            chk("b2b_serial", {15'd0, rd17},
                {15'd0, 1'b0, (pass == 0) ? 16'h5A0F : 16'hC3A5});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
